// File: rtl/nios2_debug_vjtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
package nios2_debug_vjtag_pkg;

  localparam int SR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4
  } state_t;

  // Virtual IR encodings understood by the debug slave.
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/nios2_debug_vjtag_tck_gen.sv
// TCK generator: low for TCK_DIV clk cycles then high for TCK_DIV, with
// single-cycle enables for the rising-edge sample point and the period end.
module nios2_debug_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic period_end
);

  localparam int CW = (TCK_DIV < 1) ? 1 : $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] RISE_CNT = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] HIGH_CNT = CW'(TCK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign rise       = run && (cnt == RISE_CNT);
  assign period_end = run && (cnt == LAST_CNT);

  always_comb begin
    cnt_nxt = '0;
    if (run && !period_end) cnt_nxt = cnt + 1'b1;
  end

  // tck is registered so it is a clean, glitch-free output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tck <= run && !period_end && (cnt_nxt >= HIGH_CNT);
    end
  end

endmodule

// File: rtl/nios2_debug_vjtag_master.sv
// Virtual-JTAG scan initiator: takes an IR/DR command, drives one full
// UIR-CDR-SDR-UDR scan into the debug slave and returns the captured DR.
//
// state | meaning
// IDLE  | run-test-idle, ready for a command
// UIR   | update IR, one TCK period, samples ir_out
// CDR   | capture DR, one TCK period
// SDR   | shift DR, SR_WIDTH TCK periods
// UDR   | update DR, one TCK period, then response
module nios2_debug_vjtag_master
  import nios2_debug_vjtag_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SR_WIDTH - 1);

  state_t state, state_nxt;

  logic                run;
  logic                rise;
  logic                period_end;
  logic                accept;
  logic                last_bit;
  logic [BW-1:0]       bit_cnt;
  logic [SR_WIDTH-1:0] sr;
  logic                tdo_sample;

  assign run            = (state != ST_IDLE);
  assign cmd_ready      = (state == ST_IDLE);
  assign jtag_state_rti = (state == ST_IDLE);
  assign accept         = cmd_valid && cmd_ready;
  assign last_bit       = (bit_cnt == LAST_BIT);

  assign vs_uir = (state == ST_UIR);
  assign vs_cdr = (state == ST_CDR);
  assign vs_sdr = (state == ST_SDR);
  assign vs_udr = (state == ST_UDR);
  assign tdi    = vs_sdr && sr[0];

  nios2_debug_vjtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .tck       (tck),
    .rise      (rise),
    .period_end(period_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_UIR;
      ST_UIR:  if (period_end) state_nxt = ST_CDR;
      ST_CDR:  if (period_end) state_nxt = ST_SDR;
      ST_SDR:  if (period_end && last_bit) state_nxt = ST_UDR;
      ST_UDR:  if (period_end) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_in      <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      tdo_sample <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        ir_in   <= cmd_ir;
        sr      <= cmd_data;
        bit_cnt <= '0;
      end
      if (vs_uir && rise) rsp_ir_out <= ir_out;
      if (vs_sdr && rise) tdo_sample <= tdo;
      // Shift on the falling edge of tck so tdi stays stable while tck is high.
      if (vs_sdr && period_end) begin
        sr      <= {tdo_sample, sr[SR_WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (vs_udr && period_end) begin
        rsp_data  <= sr;
        rsp_valid <= 1'b1;
        ir_in     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_debug_vjtag_master.sv
// Directed bench for the virtual-JTAG scan master at TCK_DIV=2 and TCK_DIV=1.
module tb_nios2_debug_vjtag_master;
  import nios2_debug_vjtag_pkg::*;

  localparam int SRW = 38;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default TCK_DIV=2
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_ir = '0;
  logic [SRW-1:0] cmd_data = '0;
  logic           rsp_valid;
  logic [SRW-1:0] rsp_data;
  logic [1:0]     rsp_ir_out;
  logic           tck, tdi, tdo;
  logic [1:0]     ir_in;
  logic [1:0]     ir_out = 2'b00;
  logic           vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

  // Instance B: TCK_DIV=1
  logic           b_cmd_valid = 1'b0;
  logic           b_cmd_ready;
  logic [1:0]     b_cmd_ir = '0;
  logic [SRW-1:0] b_cmd_data = '0;
  logic           b_rsp_valid;
  logic [SRW-1:0] b_rsp_data;
  logic [1:0]     b_rsp_ir_out;
  logic           b_tck, b_tdi;
  logic [1:0]     b_ir_in;
  logic           b_vs_uir, b_vs_cdr, b_vs_sdr, b_vs_udr, b_rti;

  int passed = 0;
  int total  = 0;

  nios2_debug_vjtag_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi),
    .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti)
  );

  nios2_debug_vjtag_master #(.TCK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .rsp_ir_out(b_rsp_ir_out), .tck(b_tck), .tdi(b_tdi),
    .tdo(1'b0), .ir_in(b_ir_in), .ir_out(2'b00), .vs_uir(b_vs_uir),
    .vs_cdr(b_vs_cdr), .vs_sdr(b_vs_sdr), .vs_udr(b_vs_udr), .jtag_state_rti(b_rti)
  );

  // Slave models: loopback (tdo = tdi one TCK later) or a MonDReg shifter
  logic           tdo_mode = 1'b0;
  logic           lb_tdo = 1'b0;
  logic [SRW-1:0] slave_sr = '0;
  localparam logic [SRW-1:0] SLAVE_VAL = {3'b000, 32'hDEADBEEF, 3'b000};

  always @(posedge tck) begin
    lb_tdo <= tdi;
    if (vs_cdr)      slave_sr <= SLAVE_VAL;
    else if (vs_sdr) slave_sr <= {1'b0, slave_sr[SRW-1:1]};
  end
  assign tdo = tdo_mode ? slave_sr[0] : lb_tdo;

  // Accept one command on A, then wait for its response with a cycle bound.
  task automatic run_cmd(input logic [1:0] ir, input logic [SRW-1:0] data,
                         output int lat, output int sdr_rises, output logic ready0);
    logic prev;
    @(negedge clk);
    cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    ready0 = cmd_ready;
    lat = 0; sdr_rises = 0; prev = tck;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (!prev && tck && vs_sdr) sdr_rises++;
      prev = tck;
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tck !== 1'b0 || cmd_ready !== 1'b1 || rti !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL reset_idle: %0d bad cycles, required 0", bad); else passed++;
    total++;
    if ({rsp_valid, rsp_data, rsp_ir_out, tdi, ir_in} !== '0)
      $display("FAIL reset_outputs: rsp_valid=%b rsp_data=%h rsp_ir_out=%b tdi=%b ir_in=%b, required all 0",
               rsp_valid, rsp_data, rsp_ir_out, tdi, ir_in);
    else passed++;
    total++;
    if ({vs_uir, vs_cdr, vs_sdr, vs_udr} !== 4'b0000)
      $display("FAIL reset_vs: got %b required 0000", {vs_uir, vs_cdr, vs_sdr, vs_udr});
    else passed++;
  endtask

  task automatic test_loopback;
    int lat, rises; logic r0;
    tdo_mode = 1'b0; ir_out = 2'b10;
    run_cmd(IR_BREAK, 38'h2A_5555_AAAA, lat, rises, r0);
    total++;
    if (r0 !== 1'b0) $display("FAIL ready_low_after_accept: got %b required 0", r0); else passed++;
    total++;
    if (lat !== 164) $display("FAIL latency_div2: got %0d required 164", lat); else passed++;
    total++;
    if (rises !== 38) $display("FAIL sdr_rises_div2: got %0d required 38", rises); else passed++;
    total++;
    if (rsp_data !== 38'h14_AAAB_5554)
      $display("FAIL loopback_data: got %h required %h", rsp_data, 38'h14_AAAB_5554);
    else passed++;
    total++;
    if (rsp_ir_out !== 2'b10) $display("FAIL ir_out_capture: got %b required 10", rsp_ir_out); else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ir_in !== 2'b00)
      $display("FAIL rsp_pulse_one_cycle: rsp_valid=%b cmd_ready=%b ir_in=%b required 0,1,00",
               rsp_valid, cmd_ready, ir_in);
    else passed++;
  endtask

  task automatic test_slave_read;
    int lat, rises; logic r0;
    tdo_mode = 1'b1;
    run_cmd(IR_OCIMEM, 38'h0, lat, rises, r0);
    total++;
    if (rsp_data[34:3] !== 32'hDEADBEEF)
      $display("FAIL mondreg_read: got %h required deadbeef", rsp_data[34:3]);
    else passed++;
    tdo_mode = 1'b0;
  endtask

  task automatic test_phases;
    int bad_tdi = 0, bad_ir = 0, cyc = 0;
    logic prev_tck, prev_tdi;
    @(negedge clk);
    cmd_ir = IR_TRACECTRL; cmd_data = 38'h15_5555_5555; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (tck !== 1'b0 || vs_uir !== 1'b1)
      $display("FAIL first_cycle: tck=%b vs_uir=%b required 0,1", tck, vs_uir);
    else passed++;
    prev_tck = tck; prev_tdi = tdi;
    while (!rsp_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (tdi !== prev_tdi && !(prev_tck && !tck)) bad_tdi++;
      if (!rsp_valid && ir_in !== IR_TRACECTRL) bad_ir++;
      if (!rsp_valid && ((vs_uir + vs_cdr + vs_sdr + vs_udr) != 1)) bad_ir++;
      prev_tck = tck; prev_tdi = tdi;
    end
    total++;
    if (bad_tdi !== 0) $display("FAIL tdi_change_on_fall: %0d bad changes, required 0", bad_tdi); else passed++;
    total++;
    if (bad_ir !== 0) $display("FAIL ir_in_and_strobes: %0d bad cycles, required 0", bad_ir); else passed++;
  endtask

  task automatic test_tck_div1;
    int lat = 0, rises = 0;
    logic prev;
    @(negedge clk);
    b_cmd_ir = IR_TRACEMEM; b_cmd_data = 38'h3F_0000_FFFF; b_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_cmd_valid = 1'b0;
    prev = b_tck;
    while (!b_rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (!prev && b_tck && b_vs_sdr) rises++;
      prev = b_tck;
    end
    total++;
    if (lat !== 82) $display("FAIL latency_div1: got %0d required 82", lat); else passed++;
    total++;
    if (rises !== 38) $display("FAIL sdr_rises_div1: got %0d required 38", rises); else passed++;
  endtask

  task automatic test_reset_mid_scan;
    int rises = 0, cyc = 0, seen = 0, lat, r2; logic prev, r0;
    @(negedge clk);
    cmd_ir = IR_BREAK; cmd_data = 38'h00_1234_5678; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    prev = tck;
    while (rises < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (!prev && tck && vs_sdr) rises++;
      prev = tck;
    end
    total++;
    if (rises !== 20) $display("FAIL reach_sdr20: got %0d rises required 20", rises); else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({cmd_ready, rti, rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr} !== 9'b110000000 ||
        rsp_data !== '0 || rsp_ir_out !== 2'b00 || ir_in !== 2'b00)
      $display("FAIL reset_abort: ready=%b rti=%b vs=%b tck=%b rsp_data=%h required 1,1,0000,0,0",
               cmd_ready, rti, {vs_uir, vs_cdr, vs_sdr, vs_udr}, tck, rsp_data);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL no_rsp_after_abort: got %0d pulses required 0", seen); else passed++;
    run_cmd(IR_OCIMEM, 38'h00_1234_5678, lat, r2, r0);
    total++;
    if (lat !== 164 || rsp_data !== 38'h00_2468_ACF0)
      $display("FAIL scan_after_abort: lat=%0d data=%h required 164, 0002468acf0", lat, rsp_data);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    ir_out = 2'b01;
    @(negedge clk);
    cmd_ir = IR_TRACEMEM; cmd_data = 38'h0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_ir = IR_BREAK;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 164 || cmd_ready !== 1'b1)
      $display("FAIL b2b_first: lat=%0d cmd_ready=%b required 164,1", lat, cmd_ready);
    else passed++;
    total++;
    if (rsp_ir_out !== 2'b01) $display("FAIL b2b_ir_out: got %b required 01", rsp_ir_out); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0 || vs_uir !== 1'b1 || ir_in !== IR_BREAK)
      $display("FAIL b2b_second_accept: cmd_ready=%b vs_uir=%b ir_in=%b required 0,1,10",
               cmd_ready, vs_uir, ir_in);
    else passed++;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 164) $display("FAIL b2b_second_latency: got %0d required 164", lat); else passed++;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_slave_read;
    test_phases;
    test_tck_div1;
    test_reset_mid_scan;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
